// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: accepts one clipped rectangle command and streams
// one VRAM plot strobe per cycle in raster order.
module vram_rect_fill #(
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int POS_W    = 16,
  parameter int COLOUR_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [7:0]          cmd_x,
  input  logic [6:0]          cmd_y,
  input  logic [7:0]          cmd_w,
  input  logic [6:0]          cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  output logic                plot,
  output logic [POS_W-1:0]    buf_pos,
  output logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    DRAW,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [7:0]          w_q, w_d;
  logic [6:0]          h_q, h_d;
  logic [COLOUR_W-1:0] col_q, col_d;

  logic [7:0]          cur_x_q, cur_x_d;
  logic [6:0]          cur_y_q, cur_y_d;
  logic [POS_W-1:0]    row_base_q, row_base_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                plot_q, plot_d;
  logic [POS_W-1:0]    buf_pos_q, buf_pos_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Widened sums keep x+w and y+h from wrapping before the screen clamp.
  logic [8:0]          x_sum, x_end;
  logic [7:0]          y_sum, y_end;
  logic                is_empty;
  logic                last_col;
  logic                last_row;
  logic [POS_W-1:0]    row_start;

  always_comb begin
    x_sum     = {1'b0, x_q} + {1'b0, w_q};
    y_sum     = {1'b0, y_q} + {1'b0, h_q};
    x_end     = (x_sum > 9'(H_RES)) ? 9'(H_RES) : x_sum;
    y_end     = (y_sum > 8'(V_RES)) ? 8'(V_RES) : y_sum;
    is_empty  = (w_q == 8'd0) || (h_q == 7'd0) ||
                ({1'b0, x_q} >= 9'(H_RES)) || ({1'b0, y_q} >= 8'(V_RES));
    last_col  = (({1'b0, cur_x_q} + 9'd1) == x_end);
    last_row  = (({1'b0, cur_y_q} + 8'd1) == y_end);
    row_start = POS_W'(y_q) * POS_W'(H_RES);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    row_base_d  = row_base_q;
    cmd_ready_d = cmd_ready_q;
    plot_d      = plot_q;
    buf_pos_d   = buf_pos_q;
    colour_d    = colour_q;
    busy_d      = busy_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          x_d         = cmd_x;
          y_d         = cmd_y;
          w_d         = cmd_w;
          h_d         = cmd_h;
          col_d       = cmd_colour;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = CLIP;
        end
      end

      // The only multiply happens here, once per command.
      CLIP: begin
        if (is_empty) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cur_x_d    = x_q;
          cur_y_d    = y_q;
          row_base_d = row_start;
          plot_d     = 1'b1;
          buf_pos_d  = row_start + POS_W'(x_q);
          colour_d   = col_q;
          state_d    = DRAW;
        end
      end

      // Outputs already show the current pixel; compute the following one.
      DRAW: begin
        if (last_col) begin
          if (last_row) begin
            plot_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            cur_x_d    = x_q;
            cur_y_d    = cur_y_q + 7'd1;
            row_base_d = row_base_q + POS_W'(H_RES);
            buf_pos_d  = row_base_q + POS_W'(H_RES) + POS_W'(x_q);
          end
        end else begin
          cur_x_d   = cur_x_q + 8'd1;
          buf_pos_d = row_base_q + POS_W'(cur_x_q) + POS_W'(1);
        end
      end

      DONE: begin
        done_d      = 1'b0;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      row_base_q  <= '0;
      cmd_ready_q <= 1'b1;
      plot_q      <= 1'b0;
      buf_pos_q   <= '0;
      colour_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      row_base_q  <= row_base_d;
      cmd_ready_q <= cmd_ready_d;
      plot_q      <= plot_d;
      buf_pos_q   <= buf_pos_d;
      colour_q    <= colour_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign plot      = plot_q;
  assign buf_pos   = buf_pos_q;
  assign colour    = colour_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/vram_rect_fill.md
Name: vram_rect_fill

Overview:
Command-driven rectangle fill engine that acts as the write initiator for the VRAM framebuffer port. It accepts one rectangle command (origin, size, colour) through a valid/ready handshake. It clips the rectangle to the 160x120 screen, then emits one plot strobe per cycle with the linear buf_pos and colour. CPU/graphics logic uses it in place of per-pixel software plotting.

Parameters:
H_RES, 160, screen width in pixels
V_RES, 120, screen height in pixels
POS_W, 16, width of buf_pos (linear address = y*H_RES + x)
COLOUR_W, 12, colour width (4 bits per channel, RGB)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine idle, command accepted when cmd_valid && cmd_ready
cmd_x  input  8  rectangle left column
cmd_y  input  7  rectangle top row
cmd_w  input  8  width in pixels (0 = empty)
cmd_h  input  7  height in pixels (0 = empty)
cmd_colour  input  COLOUR_W  fill colour
plot  output  1  write strobe to VRAM, one pixel per cycle
buf_pos  output  POS_W  linear pixel address for current plot
colour  output  COLOUR_W  pixel colour for current plot
busy  output  1  high from accept until done, inclusive
done  output  1  single-cycle pulse on command completion

Behaviour:
- Reset (async, active-high), all outputs registered: state=IDLE, cmd_ready=1, plot=0, buf_pos=0, colour=0, busy=0, done=0. Reset mid-draw abandons the rectangle immediately. No further plots are issued and nothing is queued.
- States: IDLE, CLIP, DRAW, DONE.
- IDLE: cmd_ready=1. On accept in cycle T, latch all cmd_* fields and go to CLIP. cmd_ready=0 and busy=1 from T+1.
- CLIP (T+1): compute x_end=min(x+w, H_RES) and y_end=min(y+h, V_RES) using 9-bit/8-bit sums so there is no wrap. The rectangle is empty if w==0, h==0, x>=H_RES or y>=V_RES. Empty: go to DONE. Otherwise load cur_x=x, cur_y=y, row_base=y*H_RES, go to DRAW.
- DRAW: plot=1, buf_pos=row_base+cur_x, colour=latched colour. The first plot is visible in cycle T+2.
  - Raster order, left to right, then top to bottom.
  - When cur_x+1==x_end: cur_x=x, cur_y+1, row_base+=H_RES.
  - After the pixel at (x_end-1, y_end-1): go to DONE.
  - row_base is updated incrementally. No multiplier in the DRAW loop.
- DONE (one cycle): plot=0, done=1, busy=1. Next cycle: IDLE, done=0, busy=0, cmd_ready=1.
- Throughput: N clipped pixels take N+3 cycles from accept to done. The engine is ready again one cycle after done.
- cmd_valid while busy is ignored (cmd_ready=0). Command fields may change freely after acceptance.
- buf_pos and colour hold their last values when plot=0. Consumers qualify on plot only.
- buf_pos never exceeds H_RES*V_RES-1 (19199).

Test Plan:
- Reset, then cmd x=0,y=0,w=2,h=2,colour=0xFFF accepted at T. Required: plot high T+2..T+5 with buf_pos 0,1,160,161 and colour 0xFFF; done at T+6; cmd_ready high at T+7.
- Clipping: x=158,y=118,w=4,h=4,colour=0xF00. Required: exactly 4 plots, buf_pos 19038,19039,19198,19199; no address >19199.
- Empty commands, each of (w=0), (h=0), (x=160), (y=120). Required: zero plots; done at T+2; cmd_ready at T+3.
- Full screen, x=0,y=0,w=255,h=127. Required: 19200 plots at consecutive addresses 0..19199 with no gaps; done one cycle after the last plot.
- Back-to-back: hold cmd_valid high with a second command during the first fill. Required: the second is accepted only in the cycle after done, and its first plot lands 2 cycles later. Command inputs changed mid-fill do not affect the first fill.
- Reset asserted asynchronously mid-DRAW (for example after 3 plots of a 10x10 fill). Required: plot=0, busy=0, cmd_ready=1 immediately; no done pulse; a new command after reset executes correctly.
